// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one decoder.
// Display updates are double-buffered and committed only between frames.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [4*NUM_DIGITS-1:0]   wr_data,
    input  logic [NUM_DIGITS-1:0]     wr_blank,
    input  logic [NUM_DIGITS-1:0]     wr_dp,
    output logic [3:0]                dig_code,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic                      dp_n,
    output logic                      frame_tick,
    output logic [1:0]                dbg_state_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0]   act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]     act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                      pend_q, pend_d;
    logic [NUM_DIGITS-1:0]     an_n_q, an_n_d;
    logic [3:0]                code_q, code_d;
    logic                      dp_n_q, dp_n_d;
    logic                      tick_q, tick_d;
    logic                      ready_q, ready_d;
    logic                      slot_end, frame_end, accept, commit;

    // Handshake: a transfer happens on any edge where wr_valid and wr_ready are both 1;
    // wr_ready stays 0 from the cycle after the transfer until the cycle after the commit.
    always_comb begin
        slot_end  = (state_q != ST_OFF) && (cnt_q == CNT_W'(DIV - 1));
        frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
        accept    = wr_valid && ready_q;
        commit    = pend_q && ((state_q == ST_OFF) || frame_end);

        act_data_d   = act_data_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;
        pend_d       = pend_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;

        if (commit) begin
            act_data_d  = pend_data_q;
            act_blank_d = pend_blank_q;
            act_dp_d    = pend_dp_q;
            pend_d      = 1'b0;
        end
        if (accept) begin
            pend_d       = 1'b1;
            pend_data_d  = wr_data;
            pend_blank_d = wr_blank;
            pend_dp_d    = wr_dp;
        end

        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                idx_d = '0;
                cnt_d = '0;
                if (en) state_d = ST_GAP;
            end
            default: begin
                if (!en) begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (slot_end) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BLANK_CYC - 1)) state_d = ST_SHOW;
                end
            end
        endcase
    end

    // Outputs are computed from next-state values so the registered outputs match the state they describe.
    always_comb begin
        an_n_d  = '1;
        dp_n_d  = 1'b1;
        code_d  = 4'h0;
        tick_d  = 1'b0;
        ready_d = ~pend_d;
        if (state_d != ST_OFF) begin
            code_d = act_data_d[{idx_d, 2'b00} +: 4];
            tick_d = (state_d == ST_SHOW) && (cnt_d == CNT_W'(DIV - 1))
                     && (idx_d == IDX_W'(NUM_DIGITS - 1));
        end
        if ((state_d == ST_SHOW) && !act_blank_d[idx_d]) begin
            an_n_d[idx_d] = 1'b0;
            dp_n_d        = ~act_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            idx_q        <= '0;
            cnt_q        <= '0;
            act_data_q   <= '0;
            act_blank_q  <= '1;
            act_dp_q     <= '0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            pend_blank_q <= '0;
            pend_dp_q    <= '0;
            an_n_q       <= '1;
            code_q       <= 4'h0;
            dp_n_q       <= 1'b1;
            tick_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            act_data_q   <= act_data_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            an_n_q       <= an_n_d;
            code_q       <= code_d;
            dp_n_q       <= dp_n_d;
            tick_q       <= tick_d;
            ready_q      <= ready_d;
        end
    end

    assign an_n        = an_n_q;
    assign dig_code    = code_q;
    assign dp_n        = dp_n_q;
    assign frame_tick  = tick_q;
    assign wr_ready    = ready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized scoreboard bench for seg7_scan_ctrl: a time-indexed display model predicts every cycle.
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ND * DIV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [15:0]   wr_data = '0;
    logic [3:0]    wr_blank = '0;
    logic [3:0]    wr_dp = '0;
    logic [3:0]    dig_code;
    logic [3:0]    an_n;
    logic          dp_n;
    logic          frame_tick;
    logic [1:0]    dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [10:0] exp_q[$];

    // Reference model: display enabled flag, cycle count since enable, active and pending images.
    bit          m_on;
    int          m_t;
    logic [15:0] m_data, p_data;
    logic [3:0]  m_blank, p_blank, m_dp, p_dp;
    bit          m_pend;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_blank(wr_blank), .wr_dp(wr_dp), .dig_code(dig_code),
        .an_n(an_n), .dp_n(dp_n), .frame_tick(frame_tick), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_on = 0; m_t = 0;
        m_data = '0; m_blank = 4'hF; m_dp = '0;
        m_pend = 0; p_data = '0; p_blank = '0; p_dp = '0;
    endtask

    // Applies the inputs as sampled at the coming clock edge.
    task automatic model_edge();
        bit xfer, commit;
        xfer   = wr_valid && !m_pend;
        commit = m_pend && (!m_on || (m_t % FRAME == FRAME - 1));
        if (commit) begin
            m_data = p_data; m_blank = p_blank; m_dp = p_dp; m_pend = 0;
        end
        if (xfer) begin
            p_data = wr_data; p_blank = wr_blank; p_dp = wr_dp; m_pend = 1;
        end
        if (!m_on) begin
            if (en) begin m_on = 1; m_t = 0; end
        end else if (!en) begin
            m_on = 0; m_t = 0;
        end else begin
            m_t = m_t + 1;
        end
    endtask

    function automatic logic [10:0] model_out();
        int slot, ph;
        logic [3:0] an, code;
        logic dp, tick;
        an = 4'hF; dp = 1'b1; code = 4'h0; tick = 1'b0;
        if (m_on) begin
            slot = (m_t / DIV) % ND;
            ph   = m_t % DIV;
            code = m_data[slot*4 +: 4];
            if (ph >= BLANK && !m_blank[slot]) begin
                an[slot] = 1'b0;
                dp = ~m_dp[slot];
            end
            tick = (ph == DIV - 1) && (slot == ND - 1);
        end
        return {an, dp, code, tick, ~m_pend};
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic write_req(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
        wr_valid = 1'b1; wr_data = d; wr_blank = b; wr_dp = p;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: the DUT presents a display vector every cycle; compare it against the oldest prediction.
    always @(negedge clk) begin
        logic [10:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {an_n, dp_n, dig_code, frame_tick, wr_ready};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL display cyc=%0d got an_n=%h dp_n=%b code=%h tick=%b ready=%b exp an_n=%h dp_n=%b code=%h tick=%b ready=%b",
                         cyc, a[10:7], a[6], a[5:2], a[1], a[0], e[10:7], e[6], e[5:2], e[1], e[0]);
            end
        end
    end

    task automatic direct_check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, want);
        end
    endtask

    initial begin
        model_reset();
        #12;
        direct_check("reset_an_n", {28'd0, an_n}, 32'hF);
        direct_check("reset_ready", {31'd0, wr_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset with scan disabled.
        run(20);

        // Update while OFF commits immediately, then start scanning.
        write_req(16'h1234, 4'h0, 4'h0);
        run(3);
        en = 1'b1;
        run(36);

        // Update arrives during digit 1; a second request while pending is ignored.
        for (int g = 0; g < 100 && !((m_t % FRAME) >= 8 && (m_t % FRAME) < 15); g++) step();
        write_req(16'hABCD, 4'h0, 4'h0);
        wr_valid = 1'b1; wr_data = 16'h5555; wr_blank = 4'h0; wr_dp = 4'hF;
        run(4);
        wr_valid = 1'b0;
        run(40);

        // Blanked digits and decimal points.
        write_req(16'h9876, 4'b1010, 4'b0101);
        run(2 * FRAME + 8);

        // Disable at cycle 20 of a frame, then re-enable.
        for (int g = 0; g < 100 && (m_t % FRAME) != 20; g++) step();
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(12);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 39) != 0);
            wr_valid = ($urandom_range(0, 7) == 0);
            wr_data  = 16'($urandom);
            wr_blank = 4'($urandom_range(0, 15));
            wr_dp    = 4'($urandom_range(0, 15));
            step();
        end
        wr_valid = 1'b0;
        en = 1'b1;
        run(FRAME + 2);

        // Asynchronous reset mid-SHOW with an update pending.
        for (int g = 0; g < 100 && !((m_t % FRAME) >= 9 && (m_t % FRAME) < 12 && !m_pend); g++) step();
        write_req(16'h4321, 4'h0, 4'hF);
        for (int g = 0; g < 20 && (m_t % DIV) < BLANK; g++) step();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        direct_check("async_rst_an_n", {28'd0, an_n}, 32'hF);
        direct_check("async_rst_ready", {31'd0, wr_ready}, 32'h1);
        direct_check("async_rst_dp_n", {31'd0, dp_n}, 32'h1);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        run(FRAME + 8);

        @(negedge clk);
        #1;
        direct_check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
